multi_delay_timer: RTL

- Multi-channel programmable delay/tick generator.
- Parametrised successor to the single-channel fixed-delay pulse generator.
- Each channel has:
  - a runtime-loadable period,
  - a periodic or one-shot mode,
  - start/stop control,
  - a registered one-cycle tick output.
- Sits beside the CPU/RAM datapath and supplies LED refresh, step and timeout strobes, replacing several hard-coded delay instances.

---
 rtl/multi_delay_timer_if.sv | 26 ++
 rtl/multi_delay_timer.sv | 89 ++++++++
 2 files changed

// File: rtl/multi_delay_timer_if.sv
// Configuration, control and status bundle for multi_delay_timer.
// The master drives writes and start/stop pulses; the slave (timer) returns ticks and busy flags.
interface multi_delay_timer_if #(
  parameter int NUM_CH   = 4,
  parameter int CNT_WDTH = 30,
  parameter int CH_IDX_W = 2
);
  logic                wr_en;
  logic [CH_IDX_W-1:0] wr_sel;
  logic [CNT_WDTH-1:0] wr_period;
  logic                wr_oneshot;
  logic [NUM_CH-1:0]   start;
  logic [NUM_CH-1:0]   stop;
  logic [NUM_CH-1:0]   tick_out;
  logic [NUM_CH-1:0]   busy;

  modport master (
    output wr_en, wr_sel, wr_period, wr_oneshot, start, stop,
    input  tick_out, busy
  );

  modport slave (
    input  wr_en, wr_sel, wr_period, wr_oneshot, start, stop,
    output tick_out, busy
  );
endinterface

// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay/tick generator: each channel counts to a loadable
// period and emits a registered one-cycle tick, either periodically or once.
module multi_delay_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WDTH       = 30,
  parameter int CH_IDX_W       = 2,
  parameter int DEFAULT_PERIOD = 1
) (
  input logic                 mclk,
  input logic                 rst,
  multi_delay_timer_if.slave  bus
);

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] busy_vec;

  assign bus.tick_out = tick_vec;
  assign bus.busy     = busy_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_t           state_reg, state_next;
    logic [CNT_WDTH-1:0] count_reg, count_next;
    logic [CNT_WDTH-1:0] period_reg, period_next;
    logic                oneshot_reg, oneshot_next;
    logic                tick_reg, tick_next;
    logic                wr_hit;

    // Out-of-range selects never match any channel, so such writes fall through silently.
    assign wr_hit = bus.wr_en && (bus.wr_sel == CH_IDX_W'(gi));

    always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      period_next  = period_reg;
      oneshot_next = oneshot_reg;
      tick_next    = 1'b0;

      if (wr_hit) begin
        period_next  = bus.wr_period;
        oneshot_next = bus.wr_oneshot;
      end

      // The >= compare lets a period lowered below the live count terminate
      // on the next edge instead of wrapping the counter.
      if (bus.stop[gi]) begin
        state_next = CH_IDLE;
        count_next = '0;
      end else if (bus.start[gi]) begin
        state_next = CH_RUN;
        count_next = '0;
      end else if (state_reg == CH_RUN && count_reg >= period_reg) begin
        count_next = '0;
        tick_next  = 1'b1;
        if (oneshot_reg) begin
          state_next = CH_IDLE;
        end
      end else if (state_reg == CH_RUN) begin
        count_next = count_reg + CNT_WDTH'(1);
      end else begin
        count_next = '0;
      end
    end

    always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
        state_reg   <= CH_IDLE;
        count_reg   <= '0;
        period_reg  <= CNT_WDTH'(DEFAULT_PERIOD);
        oneshot_reg <= 1'b0;
        tick_reg    <= 1'b0;
      end else begin
        state_reg   <= state_next;
        count_reg   <= count_next;
        period_reg  <= period_next;
        oneshot_reg <= oneshot_next;
        tick_reg    <= tick_next;
      end
    end

    assign tick_vec[gi] = tick_reg;
    assign busy_vec[gi] = (state_reg == CH_RUN);
  end

endmodule
